// File: rtl/env_adsr_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : env_adsr_fsm_if
//  Purpose  : Slot bus between the operator scheduler/register file, the
//             envelope rate counter and the envelope ADSR state machine.
//  Ports    : slot qualifiers (sample_clk_en, bank_num, op_num), key and
//             ADSR register fields, rate request to / overflow count from
//             the rate counter, and the p2 attenuation result.
//  Modports : master - scheduler / rate-counter side (drives slot inputs)
//             slave  - envelope state machine
//  Revision : 1.0 - initial release
// ============================================================================
interface env_adsr_fsm_if #(
  parameter int ENV_WIDTH                       = 9,
  parameter int BANK_NUM_WIDTH                  = 1,
  parameter int OP_NUM_WIDTH                    = 5,
  parameter int REG_ENV_WIDTH                   = 4,
  parameter int ENV_RATE_COUNTER_OVERFLOW_WIDTH = 3
);
  logic                                       sample_clk_en;
  logic [BANK_NUM_WIDTH-1:0]                  bank_num;
  logic [OP_NUM_WIDTH-1:0]                    op_num;
  logic                                       key_on;
  logic [REG_ENV_WIDTH-1:0]                   ar;
  logic [REG_ENV_WIDTH-1:0]                   dr;
  logic [REG_ENV_WIDTH-1:0]                   rr;
  logic [REG_ENV_WIDTH-1:0]                   sl;
  logic                                       egt;
  logic [REG_ENV_WIDTH-1:0]                   requested_rate_p0;
  logic [ENV_RATE_COUNTER_OVERFLOW_WIDTH-1:0] rate_counter_overflow_p1;
  logic [ENV_WIDTH-1:0]                       env_p2;
  logic                                       env_valid_p2;

  modport master (
    output sample_clk_en, bank_num, op_num, key_on, ar, dr, rr, sl, egt,
    output rate_counter_overflow_p1,
    input  requested_rate_p0, env_p2, env_valid_p2
  );

  modport slave (
    input  sample_clk_en, bank_num, op_num, key_on, ar, dr, rr, sl, egt,
    input  rate_counter_overflow_p1,
    output requested_rate_p0, env_p2, env_valid_p2
  );
endinterface
`default_nettype wire

// File: rtl/env_adsr_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : env_adsr_fsm
//  Purpose  : Time-multiplexed per-operator envelope generator. Resolves the
//             operator's ADSR phase at p0, requests a rate from the envelope
//             rate counter, applies the returned increment count at p1 and
//             writes the new {key, phase, env} entry back at p2.
//  Ports    : clk, reset (synchronous, active-high)
//             bus (slave) - slot inputs, rate request, overflow count,
//                           env_p2 / env_valid_p2 result
//  Revision : 1.0 - initial release
// ============================================================================
module env_adsr_fsm #(
  parameter int ENV_WIDTH              = 9,
  parameter int NUM_BANKS              = 2,
  parameter int NUM_OPERATORS_PER_BANK = 18
) (
  input wire logic      clk,
  input wire logic      reset,
  env_adsr_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    ATTACK  = 2'd0,
    DECAY   = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } phase_t;

  localparam int            c_ew        = ENV_WIDTH + 1;  // headroom bit
  localparam logic [c_ew-1:0] c_env_max = c_ew'((1 << ENV_WIDTH) - 1);
  localparam logic [ENV_WIDTH-1:0] c_env_silent = ENV_WIDTH'((1 << ENV_WIDTH) - 1);

  // State array
  logic                 r_key_prev [NUM_BANKS][NUM_OPERATORS_PER_BANK];
  phase_t               r_phase    [NUM_BANKS][NUM_OPERATORS_PER_BANK];
  logic [ENV_WIDTH-1:0] r_env      [NUM_BANKS][NUM_OPERATORS_PER_BANK];

  // p0 resolution
  logic                 w_slot_ok;
  logic                 w_rd_key_prev;
  phase_t               w_rd_phase;
  logic [ENV_WIDTH-1:0] w_rd_env;
  phase_t               w_phase_p0;
  logic [ENV_WIDTH-1:0] w_env_p0;
  logic [3:0]           w_rate_p0;

  // p1 stage
  logic                 r_valid_p1;
  logic                 r_wr_ok_p1;
  logic [$bits(bus.bank_num)-1:0] r_bank_p1;
  logic [$bits(bus.op_num)-1:0]   r_op_p1;
  phase_t               r_phase_p1;
  logic [ENV_WIDTH-1:0] r_env_p1;
  logic                 r_key_p1;
  logic [3:0]           r_sl_p1;
  logic                 r_egt_p1;
  logic                 r_rate_zero_p1;

  logic [2:0]           w_ovf;
  logic [c_ew-1:0]      w_env_ext;
  logic [c_ew+2:0]      w_prod;
  logic [c_ew-1:0]      w_dec;
  logic [c_ew-1:0]      w_sum;
  logic [c_ew-1:0]      w_sum_sat;
  logic [c_ew-1:0]      w_slvl;
  logic [c_ew-1:0]      w_env_next;
  phase_t               w_phase_next;

  // p2 outputs
  logic [ENV_WIDTH-1:0] r_env_p2;
  logic                 r_env_valid_p2;

  assign w_slot_ok = (int'(bus.bank_num) < NUM_BANKS) &&
                     (int'(bus.op_num) < NUM_OPERATORS_PER_BANK);

  // Combinational read and effective-phase resolution at p0.
  always_comb begin
    w_rd_key_prev = 1'b0;
    w_rd_phase    = RELEASE;
    w_rd_env      = c_env_silent;
    if (w_slot_ok) begin
      w_rd_key_prev = r_key_prev[bus.bank_num][bus.op_num];
      w_rd_phase    = r_phase[bus.bank_num][bus.op_num];
      w_rd_env      = r_env[bus.bank_num][bus.op_num];
    end

    w_phase_p0 = w_rd_phase;
    w_env_p0   = w_rd_env;
    if (!bus.key_on) begin
      w_phase_p0 = RELEASE;
    end else if (!w_rd_key_prev) begin
      // Fastest attack rate skips the attack phase entirely.
      if (bus.ar == 4'd15) begin
        w_phase_p0 = DECAY;
        w_env_p0   = '0;
      end else begin
        w_phase_p0 = ATTACK;
      end
    end

    w_rate_p0 = 4'd0;
    if (bus.sample_clk_en) begin
      case (w_phase_p0)
        ATTACK:  w_rate_p0 = bus.ar;
        DECAY:   w_rate_p0 = bus.dr;
        SUSTAIN: w_rate_p0 = bus.egt ? 4'd0 : bus.rr;
        default: w_rate_p0 = bus.rr;
      endcase
    end
  end

  assign bus.requested_rate_p0 = w_rate_p0;

  // Next-env arithmetic at p1.
  always_comb begin
    // The rate counter may still report overflow at rate 0; ignore it.
    w_ovf     = r_rate_zero_p1 ? 3'd0 : bus.rate_counter_overflow_p1;
    w_env_ext = c_ew'(r_env_p1);
    w_prod    = (c_ew + 3)'(w_env_ext + 1'b1) * (c_ew + 3)'(w_ovf);
    w_dec     = w_prod[c_ew+2:3];
    if ((w_ovf != 3'd0) && (w_dec == '0)) begin
      w_dec = c_ew'(1);
    end
    w_sum     = w_env_ext + c_ew'(w_ovf);
    w_sum_sat = (w_sum > c_env_max) ? c_env_max : w_sum;
    w_slvl    = (r_sl_p1 == 4'd15) ? c_ew'(496) : (c_ew'(r_sl_p1) << 4);

    w_phase_next = r_phase_p1;
    w_env_next   = w_env_ext;
    case (r_phase_p1)
      ATTACK: begin
        w_env_next = (w_env_ext >= w_dec) ? (w_env_ext - w_dec) : '0;
        if (w_env_next == '0) begin
          w_phase_next = DECAY;
        end
      end
      DECAY: begin
        w_env_next = w_sum_sat;
        if (w_sum_sat >= w_slvl) begin
          w_phase_next = SUSTAIN;
        end
      end
      SUSTAIN: begin
        w_env_next = r_egt_p1 ? w_env_ext : w_sum_sat;
      end
      default: begin
        w_env_next = w_sum_sat;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_p1     <= 1'b0;
      r_wr_ok_p1     <= 1'b0;
      r_env_valid_p2 <= 1'b0;
      r_env_p2       <= c_env_silent;
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int o = 0; o < NUM_OPERATORS_PER_BANK; o++) begin
          r_key_prev[b][o] <= 1'b0;
          r_phase[b][o]    <= RELEASE;
          r_env[b][o]      <= c_env_silent;
        end
      end
    end else begin
      r_valid_p1     <= bus.sample_clk_en;
      r_wr_ok_p1     <= bus.sample_clk_en & w_slot_ok;
      r_env_valid_p2 <= r_valid_p1;
      if (r_valid_p1) begin
        r_env_p2 <= w_env_next[ENV_WIDTH-1:0];
      end
      if (r_wr_ok_p1) begin
        r_key_prev[r_bank_p1][r_op_p1] <= r_key_p1;
        r_phase[r_bank_p1][r_op_p1]    <= w_phase_next;
        r_env[r_bank_p1][r_op_p1]      <= w_env_next[ENV_WIDTH-1:0];
      end
    end
    // Data side of p1 is qualified by r_valid_p1 and needs no reset.
    r_bank_p1      <= bus.bank_num;
    r_op_p1        <= bus.op_num;
    r_phase_p1     <= w_phase_p0;
    r_env_p1       <= w_env_p0;
    r_key_p1       <= bus.key_on;
    r_sl_p1        <= bus.sl;
    r_egt_p1       <= bus.egt;
    r_rate_zero_p1 <= (w_rate_p0 == 4'd0);
  end

  assign bus.env_p2       = r_env_p2;
  assign bus.env_valid_p2 = r_env_valid_p2;

endmodule
`default_nettype wire

// File: tb/tb_env_adsr_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_env_adsr_fsm
//  Purpose  : Directed self-checking bench for env_adsr_fsm.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_env_adsr_fsm;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  env_adsr_fsm_if bus ();

  env_adsr_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One slot: present at p0 (sample rate), drive ovf at p1, sample env at p2.
  // Entered and left at posedge + 1.
  task automatic do_slot(input logic bank, input logic [4:0] op, input logic key,
                         input logic [3:0] ar, input logic [3:0] dr,
                         input logic [3:0] rr, input logic [3:0] sl,
                         input logic egt, input logic [2:0] ovf,
                         output logic [3:0] rate, output logic [8:0] env,
                         output logic valid);
    bus.sample_clk_en = 1'b1;
    bus.bank_num = bank; bus.op_num = op; bus.key_on = key;
    bus.ar = ar; bus.dr = dr; bus.rr = rr; bus.sl = sl; bus.egt = egt;
    bus.rate_counter_overflow_p1 = 3'd0;
    #1;
    rate = bus.requested_rate_p0;
    @(posedge clk); #1;
    bus.sample_clk_en = 1'b0;
    bus.rate_counter_overflow_p1 = ovf;
    @(posedge clk); #1;
    env   = bus.env_p2;
    valid = bus.env_valid_p2;
    bus.rate_counter_overflow_p1 = 3'd0;
  endtask

  task automatic test_reset;
    logic [3:0] rate; logic [8:0] env; logic valid;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    n_vec++; if (bus.env_p2 !== 9'd511) begin n_err++; $display("FAIL reset_env: got %0d want 511", bus.env_p2); end
    n_vec++; if (bus.env_valid_p2 !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.env_valid_p2); end
    do_slot(1'b0, 5'd0, 1'b0, 4'd0, 4'd0, 4'd4, 4'd0, 1'b0, 3'd0, rate, env, valid);
    n_vec++; if (rate !== 4'd4) begin n_err++; $display("FAIL reset_rate: got %0d want 4", rate); end
    n_vec++; if (env !== 9'd511) begin n_err++; $display("FAIL reset_read_env: got %0d want 511", env); end
    n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL reset_read_valid: got %b want 1", valid); end
  endtask

  task automatic test_attack;
    logic [3:0] rate; logic [8:0] env; logic valid;
    int exp_env [3] = '{447, 391, 342};
    for (int i = 0; i < 3; i++) begin
      do_slot(1'b0, 5'd1, 1'b1, 4'd10, 4'd3, 4'd3, 4'd4, 1'b0, 3'd1, rate, env, valid);
      n_vec++; if (rate !== 4'd10) begin n_err++; $display("FAIL attack_rate[%0d]: got %0d want 10", i, rate); end
      n_vec++; if (env !== 9'(exp_env[i])) begin n_err++; $display("FAIL attack_env[%0d]: got %0d want %0d", i, env, exp_env[i]); end
    end
  endtask

  task automatic test_instant_attack;
    logic [3:0] rate; logic [8:0] env; logic valid;
    do_slot(1'b0, 5'd2, 1'b1, 4'd15, 4'd5, 4'd3, 4'd8, 1'b0, 3'd0, rate, env, valid);
    n_vec++; if (rate !== 4'd5) begin n_err++; $display("FAIL ar15_rate: got %0d want 5", rate); end
    n_vec++; if (env !== 9'd0) begin n_err++; $display("FAIL ar15_env: got %0d want 0", env); end
    do_slot(1'b0, 5'd2, 1'b1, 4'd15, 4'd5, 4'd3, 4'd8, 1'b0, 3'd2, rate, env, valid);
    n_vec++; if (rate !== 4'd5) begin n_err++; $display("FAIL ar15_next_rate: got %0d want 5", rate); end
    n_vec++; if (env !== 9'd2) begin n_err++; $display("FAIL ar15_decay_env: got %0d want 2", env); end
  endtask

  task automatic test_decay_sustain;
    logic [3:0] rate; logic [8:0] env; logic valid;
    do_slot(1'b0, 5'd3, 1'b1, 4'd15, 4'd7, 4'd6, 4'd2, 1'b0, 3'd0, rate, env, valid);
    for (int i = 0; i < 4; i++)
      do_slot(1'b0, 5'd3, 1'b1, 4'd15, 4'd7, 4'd6, 4'd2, 1'b0, 3'd7, rate, env, valid);
    n_vec++; if (env !== 9'd28) begin n_err++; $display("FAIL decay_env28: got %0d want 28", env); end
    do_slot(1'b0, 5'd3, 1'b1, 4'd15, 4'd7, 4'd6, 4'd2, 1'b0, 3'd7, rate, env, valid);
    n_vec++; if (rate !== 4'd7) begin n_err++; $display("FAIL decay_rate: got %0d want 7", rate); end
    n_vec++; if (env !== 9'd35) begin n_err++; $display("FAIL decay_env35: got %0d want 35", env); end
    for (int i = 0; i < 2; i++) begin
      do_slot(1'b0, 5'd3, 1'b1, 4'd15, 4'd7, 4'd6, 4'd2, 1'b1, 3'd7, rate, env, valid);
      n_vec++; if (rate !== 4'd0) begin n_err++; $display("FAIL egt_rate[%0d]: got %0d want 0", i, rate); end
      n_vec++; if (env !== 9'd35) begin n_err++; $display("FAIL egt_hold[%0d]: got %0d want 35", i, env); end
    end
    do_slot(1'b0, 5'd3, 1'b1, 4'd15, 4'd7, 4'd6, 4'd2, 1'b0, 3'd1, rate, env, valid);
    n_vec++; if (rate !== 4'd6) begin n_err++; $display("FAIL sustain_rate: got %0d want 6", rate); end
    n_vec++; if (env !== 9'd36) begin n_err++; $display("FAIL sustain_env: got %0d want 36", env); end
  endtask

  task automatic test_release;
    logic [3:0] rate; logic [8:0] env; logic valid;
    do_slot(1'b0, 5'd4, 1'b1, 4'd15, 4'd9, 4'd2, 4'd15, 1'b0, 3'd0, rate, env, valid);
    for (int i = 1; i <= 71; i++)
      do_slot(1'b0, 5'd4, 1'b1, 4'd15, 4'd9, 4'd2, 4'd15, 1'b0, 3'd7, rate, env, valid);
    n_vec++; if (rate !== 4'd9) begin n_err++; $display("FAIL long_decay_rate: got %0d want 9", rate); end
    n_vec++; if (env !== 9'd497) begin n_err++; $display("FAIL long_decay_env: got %0d want 497", env); end
    do_slot(1'b0, 5'd4, 1'b1, 4'd15, 4'd9, 4'd2, 4'd15, 1'b0, 3'd7, rate, env, valid);
    n_vec++; if (rate !== 4'd2) begin n_err++; $display("FAIL sl15_sustain_rate: got %0d want 2", rate); end
    n_vec++; if (env !== 9'd504) begin n_err++; $display("FAIL sl15_sustain_env: got %0d want 504", env); end
    do_slot(1'b0, 5'd4, 1'b1, 4'd15, 4'd9, 4'd2, 4'd15, 1'b0, 3'd5, rate, env, valid);
    n_vec++; if (env !== 9'd509) begin n_err++; $display("FAIL env509: got %0d want 509", env); end
    for (int i = 0; i < 2; i++) begin
      do_slot(1'b0, 5'd4, 1'b0, 4'd15, 4'd9, 4'd2, 4'd15, 1'b0, 3'd7, rate, env, valid);
      n_vec++; if (rate !== 4'd2) begin n_err++; $display("FAIL release_rate[%0d]: got %0d want 2", i, rate); end
      n_vec++; if (env !== 9'd511) begin n_err++; $display("FAIL release_sat[%0d]: got %0d want 511", i, env); end
    end
  endtask

  task automatic test_key_off_in_attack;
    logic [3:0] rate; logic [8:0] env; logic valid;
    do_slot(1'b0, 5'd5, 1'b1, 4'd10, 4'd3, 4'd3, 4'd4, 1'b0, 3'd1, rate, env, valid);
    n_vec++; if (env !== 9'd447) begin n_err++; $display("FAIL keyoff_pre_env: got %0d want 447", env); end
    do_slot(1'b0, 5'd5, 1'b0, 4'd10, 4'd3, 4'd3, 4'd4, 1'b0, 3'd2, rate, env, valid);
    n_vec++; if (rate !== 4'd3) begin n_err++; $display("FAIL keyoff_rate: got %0d want 3", rate); end
    n_vec++; if (env !== 9'd449) begin n_err++; $display("FAIL keyoff_env: got %0d want 449", env); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] rate; logic [8:0] env; logic valid;
    int exp_env [2] = '{447, 391};
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c >= 2) begin
        n_vec++; if (bus.env_p2 !== 9'(exp_env[(c-2)/2])) begin n_err++; $display("FAIL b2b_env[%0d]: got %0d want %0d", c-2, bus.env_p2, exp_env[(c-2)/2]); end
        n_vec++; if (bus.env_valid_p2 !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", c-2, bus.env_valid_p2); end
      end
      bus.sample_clk_en = 1'b1;
      bus.bank_num = c[0]; bus.op_num = 5'd3; bus.key_on = 1'b1;
      bus.ar = 4'd10; bus.dr = 4'd3; bus.rr = 4'd3; bus.sl = 4'd4; bus.egt = 1'b0;
      bus.rate_counter_overflow_p1 = (c >= 1) ? 3'd1 : 3'd0;
      if (c == 5) reset = 1'b1;
      #1;
      if (c < 5) begin
        n_vec++; if (bus.requested_rate_p0 !== 4'd10) begin n_err++; $display("FAIL b2b_rate[%0d]: got %0d want 10", c, bus.requested_rate_p0); end
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    bus.sample_clk_en = 1'b0;
    bus.rate_counter_overflow_p1 = 3'd0;
    for (int i = 0; i < 2; i++) begin
      n_vec++; if (bus.env_valid_p2 !== 1'b0) begin n_err++; $display("FAIL b2b_post_reset_valid[%0d]: got %b want 0", i, bus.env_valid_p2); end
      n_vec++; if (bus.env_p2 !== 9'd511) begin n_err++; $display("FAIL b2b_post_reset_env[%0d]: got %0d want 511", i, bus.env_p2); end
      @(posedge clk); #1;
    end
    for (int b = 0; b < 2; b++) begin
      do_slot(b[0], 5'd3, 1'b1, 4'd10, 4'd3, 4'd3, 4'd4, 1'b0, 3'd1, rate, env, valid);
      n_vec++; if (rate !== 4'd10) begin n_err++; $display("FAIL b2b_fresh_rate[b%0d]: got %0d want 10", b, rate); end
      n_vec++; if (env !== 9'd447) begin n_err++; $display("FAIL b2b_fresh_env[b%0d]: got %0d want 447", b, env); end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clk   = 1'b0;
    reset = 1'b1;
    bus.sample_clk_en = 1'b0;
    bus.bank_num = '0; bus.op_num = '0; bus.key_on = 1'b0;
    bus.ar = '0; bus.dr = '0; bus.rr = '0; bus.sl = '0; bus.egt = 1'b0;
    bus.rate_counter_overflow_p1 = '0;
    @(posedge clk); #1;
    test_reset();
    test_attack();
    test_instant_attack();
    test_decay_sustain();
    test_release();
    test_key_off_in_attack();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/env_adsr_fsm.md
# env_adsr_fsm

Per-operator envelope generator state machine. It consumes the per-sample increment count produced by the envelope rate counter and walks each operator's attenuation through the attack, decay, sustain and release phases. It also supplies the rate counter with the requested rate for the operator's current phase. It sits between the register file (key-on and ADSR fields) and the operator attenuation path, and serves all banks and operators time-multiplexed in the same slot order as the rate counter.

## Interface
Parameters:
- ENV_WIDTH, 9, attenuation width; 0 = loudest, 511 = silent.
- Bank/operator/register widths come from `opl3_pkg`:
  - BANK_NUM_WIDTH
  - OP_NUM_WIDTH
  - NUM_BANKS
  - NUM_OPERATORS_PER_BANK
  - REG_ENV_WIDTH = 4
  - ENV_RATE_COUNTER_OVERFLOW_WIDTH = 3

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- sample_clk_en  in  1  operator slot valid at p0
- bank_num  in  BANK_NUM_WIDTH  slot bank, p0
- op_num  in  OP_NUM_WIDTH  slot operator, p0
- key_on  in  1  operator key state, p0
- ar, dr, rr  in  REG_ENV_WIDTH each  attack, decay and release rates, p0
- sl  in  REG_ENV_WIDTH  sustain level, p0
- egt  in  1  1 = hold at sustain level, p0
- requested_rate_p0  out  REG_ENV_WIDTH  combinational rate sent to the rate counter
- rate_counter_overflow_p1  in  ENV_RATE_COUNTER_OVERFLOW_WIDTH  increment count, 0..7, from the rate counter
- env_p2  out  ENV_WIDTH  registered attenuation for the slot
- env_valid_p2  out  1  env_p2 qualifier (sample_clk_en delayed 2)

## Operation
- State array: one entry per (bank, op), NUM_BANKS × NUM_OPERATORS_PER_BANK entries. Each entry is {key_prev 1b, phase 2b, env 9b}. Phase encoding: ATTACK=0, DECAY=1, SUSTAIN=2, RELEASE=3. The array is flop-based with a combinational read at p0.
- Effective phase at p0 is resolved from the stored entry and the current inputs:
  - key_on=1 and key_prev=0 (key-on edge): ATTACK. Exception: if ar==15, env is forced to 0 and the phase is DECAY.
  - key_on=0: RELEASE, from any phase.
  - Otherwise: the stored phase.
- requested_rate_p0 by effective phase:
  - ATTACK → ar
  - DECAY → dr
  - SUSTAIN → egt ? 0 : rr
  - RELEASE → rr
  - When sample_clk_en=0, requested_rate_p0 = 0.
- Stage p1 registers: effective phase, env, key_on, sl, egt, and a flag rate_zero = (requested_rate_p0==0).
- When rate_zero=1, ovf is treated as 0. This is required because the rate counter can report a nonzero overflow at requested rate 0.
- Next-env arithmetic uses 10-bit intermediates, with ovf = rate_counter_overflow_p1:
  - ATTACK: dec = ((env+1)·ovf) >> 3, forced to a minimum of 1 when ovf≠0. env' = env − dec, saturating at 0. When env' == 0 the phase becomes DECAY.
  - DECAY: env' = env + ovf, saturating at 511. slvl = sl << 4, except sl==15 gives 496. When env' ≥ slvl the phase becomes SUSTAIN and env' is left unclamped.
  - SUSTAIN: if egt, env' = env. Otherwise env' = env + ovf, saturating at 511.
  - RELEASE: env' = env + ovf, saturating at 511. The phase stays RELEASE.
- Write-back of {key_on, phase', env'} occurs on the p2 edge when sample_clk_en_p1=1. env_p2 ≤ env' on the same edge.

## Timing
- Latency: inputs at p0 → requested_rate_p0 in the same cycle → ovf sampled at p1 → env_p2 and array write on the next edge (2 edges after p0).
- A new slot may be presented every cycle. The scheduler guarantees the same (bank, op) is not re-presented within 3 cycles, so no forwarding is required.
- Reset: on a clock edge with reset=1:
  - every entry becomes {0, RELEASE, 511};
  - env_p2 = 511 and env_valid_p2 = 0;
  - all pipeline valids clear, and in-flight writes are dropped.
- In the first cycle after reset, requested_rate_p0 reflects the reset entries.
- A key-on edge and nonzero ovf in the same slot: the edge resolves first, then the attack step applies in that slot.
- If key_on falls while in ATTACK, release proceeds from the current env with no jump.

## Test plan
- Reset, then read op 0 with key_on=0 and rr=4 → requested_rate_p0=4, env_p2=511, env_valid_p2=1 two cycles later.
- Key-on edge with ar=10 and forced ovf=1 from env=511 → env_p2 sequence 447, 391, 342; requested_rate_p0=10 throughout.
- Key-on edge with ar=15 → env_p2=0, phase DECAY, next requested_rate_p0 = dr.
- DECAY with sl=2, ovf=7, starting env=28 → env 35 followed by SUSTAIN. With egt=1 the env holds at 35 and requested_rate_p0=0, even when ovf=7 is forced.
- RELEASE from env=509 with ovf=7 → env_p2=511, and stays 511 on further slots.
- Interleaved bank 0 op 3 and bank 1 op 3 slots every cycle, with reset asserted mid-stream → both entries return to 511/RELEASE, and no stale write lands after reset.
